// File: rtl/bus_pkg.sv
// Constants shared between the bus arbiter and the frame collector.
package bus_pkg;

  localparam logic SRC_AES   = 1'b0;
  localparam logic SRC_SHA   = 1'b1;
  localparam int   BUS_ADDRW = 24;

endpackage

// File: rtl/bus_frame_collector_if.sv
// Byte-in / frame-out signal bundle of the frame collector; slave = collector side.
interface bus_frame_collector_if #(
  parameter int ADDRW = bus_pkg::BUS_ADDRW
);

  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             src_in;
  logic             out_valid;
  logic             out_ready;
  logic [ADDRW-1:0] out_addr;
  logic [7:0]       out_op;
  logic             out_src;
  logic             err_overflow;
  logic             err_frame;

  modport master (
    output byte_in, byte_valid, src_in, out_ready,
    input  out_valid, out_addr, out_op, out_src, err_overflow, err_frame
  );

  modport slave (
    input  byte_in, byte_valid, src_in, out_ready,
    output out_valid, out_addr, out_op, out_src, err_overflow, err_frame
  );

endinterface

// File: rtl/bus_frame_fifo.sv
// Frame FIFO: one-cycle push-to-valid latency; a push into a full FIFO is taken only with a same-cycle pop.
// Head data reads as zero while empty so the outputs are defined from reset.
module bus_frame_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_pop_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_pop_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/bus_frame_collector.sv
// Assembles LSB-first bytes into tagged frames and queues them; last byte to out_valid is 1 cycle, full FIFO drops (sticky err_overflow).
// Optional BFC_TIMEOUT_EN discards partial frames after TIMEOUT_CYCLES idle cycles.
module bus_frame_collector
  import bus_pkg::*;
#(
  parameter int ADDRW          = BUS_ADDRW,
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_frame_collector_if.slave  bus
);

  localparam int FW   = ADDRW + 8;
  localparam int NB   = FW / 8;
  localparam int IDXW = $clog2(NB);
  localparam logic [IDXW-1:0] LAST = IDXW'(NB - 1);

  // Illegal parameter sets surface as g_invalid_params in the elaborated hierarchy.
  if ((ADDRW % 8) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_invalid_params
  end

  logic [IDXW-1:0] r_idx;
  logic [FW-1:0]   r_asm;
  logic            r_src;
  logic            r_err_frame;
  logic            r_err_ovf;

  logic            w_src_mismatch;
  logic [IDXW-1:0] w_idx_eff;
  logic [FW-1:0]   w_asm_next;
  logic            w_frame_done;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_full;
  logic            w_empty;
  logic [FW:0]     w_pop_dat;
  logic            w_timeout;

  // A source change mid-frame restarts assembly with this byte as byte 0.
  assign w_src_mismatch = bus.byte_valid && (r_idx != '0) && (bus.src_in != r_src);
  assign w_idx_eff      = w_src_mismatch ? '0 : r_idx;
  assign w_frame_done   = bus.byte_valid && (w_idx_eff == LAST);

  always_comb begin
    w_asm_next = (w_idx_eff == '0) ? '0 : r_asm;
    w_asm_next[8*w_idx_eff +: 8] = bus.byte_in;
  end

  assign w_pop  = bus.out_valid && bus.out_ready;
  assign w_push = w_frame_done && (!w_full || w_pop);
  assign w_drop = w_frame_done && w_full && !w_pop;

`ifdef BFC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  assign w_timeout = !bus.byte_valid && (r_idx != '0) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (bus.byte_valid || (r_idx == '0) || w_timeout) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_asm       <= '0;
      r_src       <= SRC_AES;
      r_err_frame <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (bus.byte_valid) begin
        r_asm <= w_asm_next;
        r_idx <= (w_idx_eff == LAST) ? '0 : w_idx_eff + IDXW'(1);
        if (w_idx_eff == '0) r_src <= bus.src_in;
      end else if (w_timeout) begin
        r_idx <= '0;
        r_asm <= '0;
      end
      r_err_frame <= w_src_mismatch || w_timeout;
      if (w_drop) r_err_ovf <= 1'b1;
    end
  end

  bus_frame_fifo #(
    .W     (FW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat ({r_src, w_asm_next}),
    .i_pop      (w_pop),
    .o_pop_dat  (w_pop_dat),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign bus.out_valid    = !w_empty;
  assign bus.out_addr     = w_pop_dat[ADDRW-1:0];
  assign bus.out_op       = w_pop_dat[FW-1:ADDRW];
  assign bus.out_src      = w_pop_dat[FW];
  assign bus.err_overflow = r_err_ovf;
  assign bus.err_frame    = r_err_frame;

endmodule

// File: tb/tb_bus_frame_collector.sv
// Directed bench for bus_frame_collector with a frame scoreboard; honours BFC_TIMEOUT_EN.
module tb_bus_frame_collector;
  import bus_pkg::*;

  localparam int ADDRW = 24;
  typedef logic [ADDRW+8:0] frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_frame_collector_if #(.ADDRW(ADDRW)) bus();

  bus_frame_collector #(
    .ADDRW          (ADDRW),
    .DEPTH          (2),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  frame_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frames accepted on the coming edge are compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      frame_t e;
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      check("frame", {bus.out_src, bus.out_op, bus.out_addr}, e);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    bus.byte_in    = b;
    bus.src_in     = s;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic s, input bit expect_out);
    send_byte(b0, s);
    send_byte(b1, s);
    send_byte(b2, s);
    if (expect_out) sb.push_back({s, b3, b2, b1, b0});
    send_byte(b3, s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    bus.src_in     = SRC_AES;
    bus.out_ready  = 1'b0;
    repeat (2) tick();

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_out_op", bus.out_op, 0);
    check("rst_out_src", bus.out_src, 0);
    check("rst_err_overflow", bus.err_overflow, 0);
    check("rst_err_frame", bus.err_frame, 0);
    rst_n = 1'b1;
    tick();

    // Basic AES frame, one-cycle latency
    bus.out_ready = 1'b1;
    send_byte(8'h11, SRC_AES);
    send_byte(8'h22, SRC_AES);
    send_byte(8'h33, SRC_AES);
    check("no_early_valid", bus.out_valid, 0);
    sb.push_back({SRC_AES, 8'hA5, 24'h332211});
    send_byte(8'hA5, SRC_AES);
    check("latency_valid", bus.out_valid, 1);
    tick();
    check("valid_after_pop", bus.out_valid, 0);

    // Source switch mid-frame
    send_byte(8'h01, SRC_SHA);
    send_byte(8'h02, SRC_SHA);
    send_byte(8'h09, SRC_AES);
    check("err_frame_pulse", bus.err_frame, 1);
    tick();
    check("err_frame_one_cycle", bus.err_frame, 0);
    send_byte(8'h0A, SRC_AES);
    send_byte(8'h0B, SRC_AES);
    sb.push_back({SRC_AES, 8'h0C, 24'h0B0A09});
    send_byte(8'h0C, SRC_AES);
    send_frame(8'h44, 8'h55, 8'h66, 8'h77, SRC_SHA, 1'b1);
    tick();
    check("err_frame_quiet", bus.err_frame, 0);

    // Overflow with consumer stalled
    bus.out_ready = 1'b0;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, SRC_AES, 1'b1);
    send_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, SRC_SHA, 1'b1);
    check("no_overflow_yet", bus.err_overflow, 0);
    send_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4, SRC_AES, 1'b0);
    check("overflow_set", bus.err_overflow, 1);
    check("head_addr", bus.out_addr, 24'h030201);
    repeat (3) tick();
    check("head_addr_stable", bus.out_addr, 24'h030201);
    check("head_op_stable", bus.out_op, 8'h04);
    check("head_src_stable", bus.out_src, SRC_AES);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("drained_valid", bus.out_valid, 0);
    check("overflow_sticky", bus.err_overflow, 1);
    bus.out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    do_reset();
    check("overflow_cleared", bus.err_overflow, 0);
    send_frame(8'h21, 8'h22, 8'h23, 8'h24, SRC_AES, 1'b1);
    send_frame(8'h31, 8'h32, 8'h33, 8'h34, SRC_SHA, 1'b1);
    send_byte(8'h41, SRC_SHA);
    send_byte(8'h42, SRC_SHA);
    send_byte(8'h43, SRC_SHA);
    bus.out_ready = 1'b1;
    sb.push_back({SRC_SHA, 8'h44, 24'h434241});
    send_byte(8'h44, SRC_SHA);
    bus.out_ready = 1'b0;
    check("simul_no_overflow", bus.err_overflow, 0);
    check("simul_valid", bus.out_valid, 1);
    check("simul_head", bus.out_addr, 24'h333231);
    send_frame(8'h51, 8'h52, 8'h53, 8'h54, SRC_AES, 1'b0);
    check("still_full", bus.err_overflow, 1);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("simul_drained", bus.out_valid, 0);
    check("simul_sb_empty", sb.size(), 0);

    // Idle gap inside a frame
    do_reset();
    send_byte(8'hC1, SRC_SHA);
    send_byte(8'hC2, SRC_SHA);
    for (int i = 0; i < 15; i++) begin
      tick();
`ifdef BFC_TIMEOUT_EN
      check("idle_err_frame", bus.err_frame, (i == 14) ? 1 : 0);
`else
      check("idle_err_frame", bus.err_frame, 0);
`endif
    end
`ifdef BFC_TIMEOUT_EN
    send_frame(8'hD1, 8'hD2, 8'hD3, 8'hD4, SRC_AES, 1'b1);
`else
    send_byte(8'hC3, SRC_SHA);
    sb.push_back({SRC_SHA, 8'hC4, 24'hC3C2C1});
    send_byte(8'hC4, SRC_SHA);
`endif
    repeat (2) tick();
    check("idle_sb_empty", sb.size(), 0);
    check("idle_no_err", bus.err_frame, 0);

    // Reset mid-frame with a queued frame
    bus.out_ready = 1'b0;
    send_frame(8'h61, 8'h62, 8'h63, 8'h64, SRC_AES, 1'b0);
    send_byte(8'h71, SRC_AES);
    send_byte(8'h72, SRC_AES);
    send_byte(8'h73, SRC_AES);
    check("pre_reset_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", bus.out_valid, 0);
    check("async_addr", bus.out_addr, 0);
    check("async_op", bus.out_op, 0);
    check("async_src", bus.out_src, 0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    send_frame(8'h81, 8'h82, 8'h83, 8'h84, SRC_SHA, 1'b1);
    repeat (2) tick();
    check("post_reset_sb_empty", sb.size(), 0);
    check("post_reset_err_frame", bus.err_frame, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_frame_collector.md
BUS_FRAME_COLLECTOR -- requirements
Module: bus_frame_collector

Interface
REQ-001 Parameter ADDRW, default 24: address field width; SHALL be a multiple of 8; frame width FW = ADDRW+8; bytes per frame NB = FW/8.
REQ-002 Parameter DEPTH, default 2: output FIFO entries; SHALL be a power of two and at least 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 15: inter-byte idle limit; used only with BFC_TIMEOUT_EN.
REQ-004 Ports, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- byte_in  in  8  serialized frame byte from bus arbiter.
- byte_valid  in  1  byte_in carries a valid byte this cycle.
- src_in  in  1  byte source: 0 AES, 1 SHA.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts frame.
- out_addr  out  ADDRW  frame bits [ADDRW-1:0].
- out_op  out  8  frame bits [FW-1:ADDRW].
- out_src  out  1  source tag of frame.
- err_overflow  out  1  sticky: frame dropped because FIFO full.
- err_frame  out  1  one-cycle pulse: partial frame discarded.

Function
REQ-005 Bytes SHALL be assembled LSB-first: byte k of a frame lands in frame bits [8k+7:8k], k = 0..NB-1.
REQ-006 A byte index counter (0..NB-1) SHALL advance only on byte_valid and wrap to 0 after byte NB-1.
REQ-007 The collector SHALL latch src_in on byte 0 and tag the frame with it.
REQ-008 If byte_valid with index != 0 and src_in differs from the latched source, the collector SHALL discard the partial frame, pulse err_frame, and take this byte as byte 0 of a new frame.
REQ-009 On byte NB-1, the completed frame SHALL be pushed into the FIFO in the same cycle; out_valid SHALL assert no earlier than the next cycle (1-cycle latency from last byte to out_valid when FIFO was empty).
REQ-010 A frame transfers to the consumer on the cycle out_valid && out_ready is true; out_addr/out_op/out_src SHALL be stable while out_valid && !out_ready.
REQ-011 FIFO order SHALL be strictly first-in first-out; no reordering between sources.
REQ-012 When the FIFO is full, push SHALL still be accepted if a pop occurs in the same cycle.
REQ-013 When the FIFO is full and no pop occurs in the push cycle, the frame SHALL be dropped and err_overflow set; FIFO contents SHALL be unchanged.
REQ-014 err_overflow SHALL remain set until reset.
REQ-015 FIFO pointers SHALL wrap modulo DEPTH; an occupancy counter of width clog2(DEPTH)+1 SHALL distinguish full from empty.
REQ-016 out_valid SHALL equal (occupancy != 0).

Reset
REQ-017 On rst_n low, asynchronously: byte index 0, assembly register 0, latched source 0, FIFO empty, out_valid 0, out_addr 0, out_op 0, out_src 0, err_overflow 0, err_frame 0, timeout counter 0.
REQ-018 Reset mid-frame or with a non-empty FIFO SHALL discard all held data; the first byte after reset release is byte 0.

Configuration
REQ-019 Macro BFC_TIMEOUT_EN, when defined: an idle counter SHALL count cycles without byte_valid while index != 0. On reaching TIMEOUT_CYCLES, the collector SHALL discard the partial frame, reset the index to 0 and pulse err_frame; a byte_valid clears the counter.
REQ-020 Without BFC_TIMEOUT_EN: no idle counter SHALL exist, and a partial frame SHALL be held indefinitely.

Structure
REQ-021 Shared package bus_pkg SHALL hold SRC_AES = 1'b0, SRC_SHA = 1'b1, and the default ADDRW constant, shared with the bus arbiter.
REQ-022 The FIFO SHALL be a sub-module bus_frame_fifo (width FW+1, depth DEPTH, push/pop/full/empty); assembly and error logic stay in the top.

Verification
REQ-023 AES bytes 0x11, 0x22, 0x33, 0xA5 on consecutive cycles, out_ready=1 -> out_valid 1 cycle after 0xA5 with out_addr 0x332211, out_op 0xA5, out_src 0.
REQ-024 SHA bytes 0x01, 0x02, then an AES byte 0x09 -> err_frame pulses 1 cycle; 0x09 becomes byte 0 of the new AES frame.
REQ-025 out_ready=0, three complete frames with DEPTH=2 -> first two held in order, third dropped, err_overflow=1; raising out_ready drains the first two in order.
REQ-026 FIFO full, last byte arrives in the same cycle out_ready=1 -> no drop, err_overflow stays 0, occupancy stays 2.
REQ-027 With BFC_TIMEOUT_EN: two bytes then 15 idle cycles -> err_frame pulse, index 0; without the macro, the next two bytes complete the frame.
REQ-028 rst_n asserted after byte 2 of a frame -> all outputs 0 immediately; the next four bytes form a clean frame.
